// File: rtl/pipe_mdu.sv
// ============================================================================
// pipe_mdu : iterative multiply/divide unit owning the HI/LO registers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module pipe_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clrn,
    input  logic             clk,
    input  logic             estart,
    input  logic [2:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor
    logic [WIDTH-1:0] orig_q, orig_d;   // raw dividend for the divide-by-zero result
    logic             is_div_q, is_div_d;
    logic             rsign_q, rsign_d;
    logic             dsign_q, dsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0]   ea_abs, eb_abs;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dshift;
    logic               dborrow;
    logic [WIDTH-1:0]   dlow;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign ea_abs   = ea[WIDTH-1] ? -ea : ea;
    assign eb_abs   = eb[WIDTH-1] ? -eb : eb;
    assign msum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    assign dshift   = {acc_q, mq_q[WIDTH-1]};
    // A non-borrowing difference is always below the divisor, so WIDTH bits suffice.
    assign dborrow  = dshift < {1'b0, opnd_q};
    assign dlow     = dshift[WIDTH-1:0] - opnd_q;
    assign prod     = {acc_q, mq_q};
    assign prod_neg = -prod;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            orig_q   <= '0;
            is_div_q <= 1'b0;
            rsign_q  <= 1'b0;
            dsign_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            orig_q   <= orig_d;
            is_div_q <= is_div_d;
            rsign_q  <= rsign_d;
            dsign_q  <= dsign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        orig_d   = orig_q;
        is_div_d = is_div_q;
        rsign_d  = rsign_q;
        dsign_d  = dsign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (estart) begin
                    case (eop)
                        OP_MULT, OP_DIV: begin
                            mq_d     = ea_abs;
                            opnd_d   = eb_abs;
                            rsign_d  = ea[WIDTH-1] ^ eb[WIDTH-1];
                            dsign_d  = ea[WIDTH-1];
                            acc_d    = '0;
                            orig_d   = ea;
                            is_div_d = (eop == OP_DIV);
                            cnt_d    = '0;
                            state_d  = RUN;
                        end
                        OP_MULTU, OP_DIVU: begin
                            mq_d     = ea;
                            opnd_d   = eb;
                            rsign_d  = 1'b0;
                            dsign_d  = 1'b0;
                            acc_d    = '0;
                            orig_d   = ea;
                            is_div_d = (eop == OP_DIVU);
                            cnt_d    = '0;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = ea;
                        OP_MTLO: lo_d = ea;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = dborrow ? dshift[WIDTH-1:0] : dlow;
                    mq_d  = {mq_q[WIDTH-2:0], ~dborrow};
                end else begin
                    {acc_d, mq_d} = {msum, mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = rsign_q ? prod_neg : prod;
                end else if (opnd_q == '0) begin
                    lo_d = '1;
                    hi_d = orig_q;
                end else begin
                    lo_d = rsign_q ? -mq_q : mq_q;
                    hi_d = dsign_q ? -acc_q : acc_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mdu.sv
// ============================================================================
// tb_pipe_mdu : directed self-checking bench for pipe_mdu
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_pipe_mdu;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic        clk = 1'b0;
    logic        clrn;
    logic        estart;
    logic [2:0]  eop;
    logic [31:0] ea, eb;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic allow_overlap = 1'b0;

    pipe_mdu #(.WIDTH(32)) dut (
        .clrn   (clrn),
        .clk    (clk),
        .estart (estart),
        .eop    (eop),
        .ea     (ea),
        .eb     (eb),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Decode must stall while busy; only the deliberate overlap test may break that.
    always @(posedge clk) begin
        assert (!(clrn && estart && busy && !allow_overlap))
            else $error("estart asserted while busy");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        estart = 1'b1; eop = op; ea = a; eb = b;
        @(posedge clk); #1;
        estart = 1'b0; eop = OP_NONE; ea = '0; eb = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; estart = 1'b0; eop = OP_NONE; ea = '0; eb = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        clrn = 1'b1;
    endtask

    task automatic test_multiply();
        logic [2:0]  ops [3] = '{OP_MULTU, OP_MULT, OP_MULT};
        logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000};
        logic [31:0] ehi [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
        logic [31:0] elo [3] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            count_busy(n);
            checks++;
            if (n !== 33) begin
                errors++;
                $display("FAIL mul%0d_busy_cycles: got %0d required 33", i, n);
            end
            checks++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                errors++;
                $display("FAIL mul%0d_result: hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [3] = '{OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] bs  [3] = '{32'h00000002, 32'd7,   32'hFFFFFFFF};
        logic [31:0] ehi [3] = '{32'hFFFFFFFF, 32'd2,   32'h00000000};
        logic [31:0] elo [3] = '{32'hFFFFFFFD, 32'd14,  32'h80000000};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            count_busy(n);
            checks++;
            if (n !== 33) begin
                errors++;
                $display("FAIL div%0d_busy_cycles: got %0d required 33", i, n);
            end
            checks++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                errors++;
                $display("FAIL div%0d_result: hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [2:0]  ops [2] = '{OP_DIVU, OP_DIV};
        logic [31:0] as  [2] = '{32'h00001234, 32'hFFFFFF00};
        int n;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], as[i], 32'h0);
            count_busy(n);
            checks++;
            if (n !== 33) begin
                errors++;
                $display("FAIL divzero%0d_busy_cycles: got %0d required 33", i, n);
            end
            checks++;
            if (hi !== as[i] || lo !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL divzero%0d_result: hi=%h lo=%h required hi=%h lo=ffffffff", i, hi, lo, as[i]);
            end
        end
    endtask

    task automatic test_mt();
        logic [31:0] lo_before;
        lo_before = lo;
        @(negedge clk);
        estart = 1'b1; eop = OP_MTHI; ea = 32'hDEADBEEF;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'hDEADBEEF || lo !== lo_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b required hi=deadbeef lo=%h busy=0", hi, lo, busy, lo_before);
        end
        eop = OP_MTLO; ea = 32'h0BADF00D;
        @(posedge clk); #1;
        estart = 1'b0; eop = OP_NONE; ea = '0;
        checks++;
        if (hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b required hi=deadbeef lo=0badf00d busy=0", hi, lo, busy);
        end
    endtask

    task automatic test_nop();
        logic [2:0] ops [2] = '{OP_NONE, OP_RSVD};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            estart = 1'b1; eop = ops[i]; ea = 32'h5555AAAA; eb = 32'h3;
            @(posedge clk); #1;
            estart = 1'b0; eop = OP_NONE;
            checks++;
            if (busy !== 1'b0 || hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D) begin
                errors++;
                $display("FAIL nop%0d: busy=%b hi=%h lo=%h required busy=0 hi=deadbeef lo=0badf00d", i, busy, hi, lo);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        allow_overlap = 1'b1;
        estart = 1'b1; eop = OP_MTHI; ea = 32'h11111111;
        @(posedge clk); #1;
        estart = 1'b0; eop = OP_NONE; ea = '0;
        allow_overlap = 1'b0;
        checks++;
        if (hi !== 32'hDEADBEEF || busy !== 1'b1) begin
            errors++;
            $display("FAIL mthi_while_busy: hi=%h busy=%b required hi=deadbeef busy=1", hi, busy);
        end
        count_busy(n);
        checks++;
        if (n !== 28 || hi !== 32'h0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL overlap_result: remaining=%0d hi=%h lo=%h required remaining=28 hi=0 lo=6", n, hi, lo);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        issue(OP_MULT, 32'h00012345, 32'hFFFF0001);
        repeat (9) @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
        end
        @(negedge clk);
        clrn = 1'b1;
        issue(OP_MULTU, 32'd3, 32'd5);
        count_busy(n);
        checks++;
        if (n !== 33 || hi !== 32'h0 || lo !== 32'd15) begin
            errors++;
            $display("FAIL after_reset_multu: cycles=%0d hi=%h lo=%h required cycles=33 hi=0 lo=f", n, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_mt();
        test_nop();
        test_busy_ignore();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_mdu.md
Name: pipe_mdu

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage pipelined CPU.
- Consumes the ID/EX register outputs: operands ea/eb plus an op code and start strobe added to that register.
- Owns the HI/LO architectural registers, serving mfhi/mflo and mthi/mtlo.
- Raises busy so the decode stage stalls dependent instructions.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits, product is 2*WIDTH.

Ports:
- clrn   input   1   asynchronous active-low reset
- clk    input   1   clock; all state updates on posedge
- estart input   1   one-cycle qualifier for eop/ea/eb from the ID/EX register
- eop    input   3   000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
- ea     input   32  rs operand: multiplicand / dividend / mt source
- eb     input   32  rt operand: multiplier / divisor
- busy   output  1   registered; high while an operation is in flight
- hi     output  32  HI register
- lo     output  32  LO register

Behaviour:
- Reset: clrn=0 forces, asynchronously:
  - state IDLE, cnt=0, hi=0, lo=0, busy=0
  - internal accumulator, operand and sign registers cleared
  - applies mid-operation too: the result is discarded, nothing is written.
- States: IDLE, RUN, FIX. busy = (state != IDLE).
- IDLE, estart=1 with eop 001..100 (edge E0):
  - For signed ops (MULT/DIV), latch |ea| and |eb|, the result sign (sign(ea) xor sign(eb)) and the dividend sign (sign(ea)).
  - For unsigned ops, latch ea and eb raw.
  - cnt=0, go to RUN.
- RUN, edges E1..E32: one radix-2 step per edge.
  - Multiply: shift-add into a 64-bit {acc,mplr}.
  - Divide: restoring shift-subtract, giving the quotient and a 32-bit remainder.
  - cnt increments; on the edge where cnt==31, go to FIX.
- FIX, edge E33: apply sign correction, write hi/lo, go to IDLE.
  - MULT: negate the 64-bit product if the result sign is set; hi=product[63:32], lo=product[31:0].
  - DIV: negate the quotient if the result sign is set; negate the remainder if the dividend was negative. lo=quotient, hi=remainder. Quotient truncates toward zero.
  - Unsigned ops: no correction.
- Timing: busy is high for exactly 33 cycles, after E0 through E33. New hi/lo are visible after E33.
- Divide by zero (eb==0):
  - lo=0xFFFFFFFF, hi=ea (original value), for both DIV and DIVU.
  - No sign correction; latency unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, with no exception.
- MTHI/MTLO in IDLE: hi (or lo) = ea on the same edge; busy stays 0.
- estart while busy:
  - Any op is ignored and in-flight state is undisturbed; the decode stall guarantees this case does not occur.
  - The bench flags it as an assertion.
- eop 000 or 111 with estart: no effect.
- estart=0: eop, ea and eb are don't-care.
- hi and lo hold their values at all times except on the FIX edge, an MT write, or reset.

Test Plan:
- MULTU ea=0xFFFFFFFF, eb=0xFFFFFFFF -> busy high 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT ea=0xFFFFFFFD (-3), eb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV ea=-7 (0xFFFFFFF9), eb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU ea=0x1234, eb=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
- MTHI ea=0xDEADBEEF, then next cycle MTLO ea=0x0BADF00D -> hi and lo update one edge each, busy never asserts; MTHI issued while busy -> ignored, hi unchanged.
- Start MULT, pull clrn low at cycle 10 -> busy=0, hi=lo=0 immediately; a fresh MULTU 3x5 after release -> lo=15, hi=0 at cycle 33.
